// File: rtl/cam_sensor_emulator.sv
// Camera sensor emulator: generates a DVP-style pixel clock, vsync/href framing
// and YUV422 test-pattern bytes (Y first, chroma fixed at 8'h80).
// Ports:
//   sys_clk, nreset         - system clock, asynchronous active-low reset
//   start                   - one-cycle frame request (ignored while busy)
//   continuous              - repeat frames back-to-back when sampled high at frame end
//   pattern, bar_col        - test pattern select and bar start pixel (latched per frame)
//   cam_pclk                - emulated pixel clock (half-period CLK_DIV sys_clk cycles)
//   cam_vsync, cam_href     - frame/line framing, updated only on pclk falling edges
//   cam_data                - pixel byte, updated only on pclk falling edges
//   busy, frame_done        - frame in progress, one-cycle end-of-frame pulse
module cam_sensor_emulator #(
  parameter int unsigned CLK_DIV      = 1,
  parameter int unsigned H_PIXELS     = 32,
  parameter int unsigned V_LINES      = 2,
  parameter int unsigned VSYNC_PCLKS  = 4,
  parameter int unsigned VBP_PCLKS    = 8,
  parameter int unsigned HBLANK_PCLKS = 8,
  parameter int unsigned VFP_PCLKS    = 8,
  parameter logic [7:0]  Y_DARK       = 8'd50,
  parameter logic [7:0]  Y_LIGHT      = 8'd200,
  parameter int unsigned BAR_W        = 4
) (
  input  logic       sys_clk,
  input  logic       nreset,
  input  logic       start,
  input  logic       continuous,
  input  logic [1:0] pattern,
  input  logic [7:0] bar_col,
  output logic       cam_pclk,
  output logic       cam_vsync,
  output logic       cam_href,
  output logic [7:0] cam_data,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned BYTES = 2 * H_PIXELS;
  localparam int unsigned BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned LW    = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int unsigned DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PM_A  = (VSYNC_PCLKS > VBP_PCLKS) ? VSYNC_PCLKS : VBP_PCLKS;
  localparam int unsigned PM_B  = (HBLANK_PCLKS > VFP_PCLKS) ? HBLANK_PCLKS : VFP_PCLKS;
  localparam int unsigned PMAX  = (PM_A > PM_B) ? PM_A : PM_B;
  localparam int unsigned PW    = (PMAX > 1) ? $clog2(PMAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBP    = 3'd2,
    S_LINE   = 3'd3,
    S_HBLANK = 3'd4,
    S_VFP    = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic            pclk_q, pclk_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [BW-1:0]   byte_q, byte_d;
  logic [LW-1:0]   line_q, line_d;
  logic            vsync_q, vsync_d;
  logic            href_q, href_d;
  logic [7:0]      data_q, data_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;
  logic            start_pend_q, start_pend_d;
  logic [1:0]      pattern_q, pattern_d;
  logic [7:0]      bar_col_q, bar_col_d;

  logic            div_last_c;
  logic            tick_c;
  logic            go_c;
  logic            phase_done_c;
  logic            line_end_c;
  logic            last_line_c;

  // Byte for index byte_idx of line line_idx under the latched pattern.
  function automatic logic [7:0] byte_value(input logic [1:0]    pat,
                                            input logic [7:0]    bar,
                                            input logic [BW-1:0] byte_idx,
                                            input logic [LW-1:0] line_idx);
    logic [BW-1:0] x;
    logic [8:0]    x9;
    logic [8:0]    bar_lo;
    logic [8:0]    bar_hi;
    logic [7:0]    y;
    x      = byte_idx >> 1;
    x9     = 9'(x);
    bar_lo = {1'b0, bar};
    bar_hi = bar_lo + 9'(BAR_W);
    case (pat)
      2'd0:    y = x[0] ? Y_LIGHT : Y_DARK;
      2'd1:    y = ((x9 >= bar_lo) && (x9 < bar_hi)) ? Y_DARK : Y_LIGHT;
      2'd2:    y = 8'(x) + 8'(line_idx);
      default: y = Y_LIGHT;
    endcase
    byte_value = byte_idx[0] ? 8'h80 : y;
  endfunction

  // Pixel clock divider; a tick is the sys_clk cycle where pclk falls.
  always_comb begin
    div_last_c = (div_cnt_q == DW'(CLK_DIV - 1));
    div_cnt_d  = div_last_c ? '0 : div_cnt_q + DW'(1);
    pclk_d     = div_last_c ? ~pclk_q : pclk_q;
    tick_c     = div_last_c & pclk_q;
  end

  // Phase-length, line-end and frame-request conditions.
  always_comb begin
    go_c        = start_pend_q | start;
    line_end_c  = (byte_q == BW'(BYTES - 1));
    last_line_c = (line_q == LW'(V_LINES - 1));
    case (state_q)
      S_VSYNC:  phase_done_c = (phase_q == PW'(VSYNC_PCLKS - 1));
      S_VBP:    phase_done_c = (phase_q == PW'(VBP_PCLKS - 1));
      S_HBLANK: phase_done_c = (phase_q == PW'(HBLANK_PCLKS - 1));
      S_VFP:    phase_done_c = (phase_q == PW'(VFP_PCLKS - 1));
      default:  phase_done_c = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk or negedge nreset) begin
    if (!nreset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; transitions only happen on ticks.
  always_comb begin
    state_d = state_q;
    if (tick_c) begin
      case (state_q)
        S_IDLE:   if (go_c) state_d = S_VSYNC;
        S_VSYNC:  if (phase_done_c) state_d = S_VBP;
        S_VBP:    if (phase_done_c) state_d = S_LINE;
        S_LINE:   if (line_end_c) state_d = last_line_c ? S_VFP : S_HBLANK;
        S_HBLANK: if (phase_done_c) state_d = S_LINE;
        S_VFP:    if (phase_done_c) state_d = continuous ? S_VSYNC : S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Output and datapath next values; outputs move only on ticks.
  always_comb begin
    vsync_d      = vsync_q;
    href_d       = href_q;
    data_d       = data_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    start_pend_d = start_pend_q | (start & ~busy_q);
    pattern_d    = pattern_q;
    bar_col_d    = bar_col_q;
    phase_d      = phase_q;
    byte_d       = byte_q;
    line_d       = line_q;
    if (tick_c) begin
      case (state_q)
        S_IDLE: begin
          vsync_d = 1'b1;
          href_d  = 1'b0;
          data_d  = 8'd0;
          if (go_c) begin
            busy_d       = 1'b1;
            start_pend_d = 1'b0;
            pattern_d    = pattern;
            bar_col_d    = bar_col;
            phase_d      = '0;
          end
        end
        S_VSYNC: begin
          if (phase_done_c) begin
            vsync_d = 1'b0;
            phase_d = '0;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
        S_VBP: begin
          if (phase_done_c) begin
            href_d = 1'b1;
            byte_d = '0;
            line_d = '0;
            data_d = byte_value(pattern_q, bar_col_q, '0, '0);
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
        S_LINE: begin
          if (line_end_c) begin
            href_d  = 1'b0;
            data_d  = 8'd0;
            phase_d = '0;
          end else begin
            byte_d = byte_q + BW'(1);
            data_d = byte_value(pattern_q, bar_col_q, byte_q + BW'(1), line_q);
          end
        end
        S_HBLANK: begin
          if (phase_done_c) begin
            href_d = 1'b1;
            byte_d = '0;
            line_d = line_q + LW'(1);
            data_d = byte_value(pattern_q, bar_col_q, '0, line_q + LW'(1));
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
        S_VFP: begin
          if (phase_done_c) begin
            vsync_d      = 1'b1;
            frame_done_d = 1'b1;
            phase_d      = '0;
            if (continuous) begin
              pattern_d = pattern;
              bar_col_d = bar_col;
            end else begin
              busy_d = 1'b0;
            end
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
        default: begin
          vsync_d = 1'b1;
          href_d  = 1'b0;
          data_d  = 8'd0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge sys_clk or negedge nreset) begin
    if (!nreset) begin
      div_cnt_q    <= '0;
      pclk_q       <= 1'b0;
      phase_q      <= '0;
      byte_q       <= '0;
      line_q       <= '0;
      vsync_q      <= 1'b1;
      href_q       <= 1'b0;
      data_q       <= 8'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      start_pend_q <= 1'b0;
      pattern_q    <= 2'd0;
      bar_col_q    <= 8'd0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      pclk_q       <= pclk_d;
      phase_q      <= phase_d;
      byte_q       <= byte_d;
      line_q       <= line_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      start_pend_q <= start_pend_d;
      pattern_q    <= pattern_d;
      bar_col_q    <= bar_col_d;
    end
  end

  assign cam_pclk   = pclk_q;
  assign cam_vsync  = vsync_q;
  assign cam_href   = href_q;
  assign cam_data   = data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_cam_sensor_emulator.sv
// Bench for cam_sensor_emulator: a frame-level stream model (expected samples at
// every pclk rising edge) checked each cycle, plus literal checks on captured bytes.
module tb_cam_sensor_emulator;

  localparam int HP  = 32;
  localparam int VL  = 2;
  localparam int VS  = 4;
  localparam int VBP = 8;
  localparam int HB  = 8;
  localparam int VFP = 8;

  logic       sys_clk = 1'b0;
  logic       nreset = 1'b0;
  logic       start = 1'b0;
  logic       start3 = 1'b0;
  logic       continuous = 1'b0;
  logic [1:0] pattern = 2'd0;
  logic [7:0] bar_col = 8'd0;

  logic       cam_pclk, cam_vsync, cam_href, busy, frame_done;
  logic [7:0] cam_data;
  logic       pclk3, vsync3, href3, busy3, fd3;
  logic [7:0] data3;

  int total = 0;
  int bad = 0;

  always #5 sys_clk = ~sys_clk;

  cam_sensor_emulator dut (
    .sys_clk(sys_clk), .nreset(nreset), .start(start), .continuous(continuous),
    .pattern(pattern), .bar_col(bar_col), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .busy(busy), .frame_done(frame_done)
  );

  cam_sensor_emulator #(.CLK_DIV(3)) dut3 (
    .sys_clk(sys_clk), .nreset(nreset), .start(start3), .continuous(continuous),
    .pattern(pattern), .bar_col(bar_col), .cam_pclk(pclk3), .cam_vsync(vsync3),
    .cam_href(href3), .cam_data(data3), .busy(busy3), .frame_done(fd3)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Luma from the pattern rules, in plain integer arithmetic.
  function automatic int exp_y(input int pat, input int bar, input int x, input int y);
    case (pat)
      0:       return (x % 2 == 0) ? 50 : 200;
      1:       return (x >= bar && x < bar + 4) ? 50 : 200;
      2:       return (x + y) % 256;
      default: return 200;
    endcase
  endfunction

  typedef struct {
    logic       vs;
    logic       hr;
    logic [7:0] d;
  } samp_t;

  samp_t exp_q[$];

  // Expected rising-edge samples for one whole frame after its start tick.
  task automatic push_frame(input int pat, input int bar);
    samp_t s;
    s = '{1'b1, 1'b0, 8'd0};
    repeat (VS) exp_q.push_back(s);
    s = '{1'b0, 1'b0, 8'd0};
    repeat (VBP) exp_q.push_back(s);
    for (int y = 0; y < VL; y++) begin
      for (int b = 0; b < 2 * HP; b++) begin
        s.vs = 1'b0;
        s.hr = 1'b1;
        s.d  = (b % 2 == 1) ? 8'h80 : 8'(exp_y(pat, bar, b / 2, y));
        exp_q.push_back(s);
      end
      if (y < VL - 1) begin
        s = '{1'b0, 1'b0, 8'd0};
        repeat (HB) exp_q.push_back(s);
      end
    end
    s = '{1'b0, 1'b0, 8'd0};
    repeat (VFP) exp_q.push_back(s);
  endtask

  // Model / observation state
  logic       pclk_p = 1'b0, rst_p = 1'b0, cont_p = 1'b0;
  logic [1:0] pat_p = 2'd0;
  logic [7:0] bar_p = 8'd0;
  logic       vs_p = 1'b1, hr_p = 1'b0, hr_sp = 1'b0;
  logic [7:0] d_p = 8'd0;
  bit         armed = 1'b0, in_frame = 1'b0, vs_counting = 1'b0;
  int         n_done = 0, fd_cnt = 0, vs_cnt = 0, vs_fall = -1;
  int         href_pulses = 0, href_len = 0, lowrun = 0;
  int         lens[$];
  int         runs[$];
  logic [7:0] cap[2][64];
  // CLK_DIV=3 instance observation
  logic       p3_p = 1'b0, hr3_sp = 1'b0;
  logic       vs3_p = 1'b1, hr3_p = 1'b0;
  logic [7:0] d3_p = 8'd0;
  int         cyc = 0, last_rise3 = -1, idx3 = 0, n_done3 = 0, len3 = 0;
  int         lens3[$];

  always @(negedge sys_clk) begin : monitor
    bit    rose, fell, exp_fd, rose3, fell3;
    samp_t e;
    cyc++;
    if (frame_done === 1'b1) fd_cnt++;
    if (fd3 === 1'b1) n_done3++;
    rose  = (pclk_p == 1'b0) && (cam_pclk == 1'b1);
    fell  = (pclk_p == 1'b1) && (cam_pclk == 1'b0);
    rose3 = (p3_p == 1'b0) && (pclk3 == 1'b1);
    fell3 = (p3_p == 1'b1) && (pclk3 == 1'b0);
    if (!nreset) begin
      exp_q.delete();
      armed      = 1'b0;
      in_frame   = 1'b0;
      last_rise3 = -1;
    end else begin
      if (rose) begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '{1'b1, 1'b0, 8'd0};
        chk("vsync", int'(cam_vsync), int'(e.vs));
        chk("href", int'(cam_href), int'(e.hr));
        chk("data", int'(cam_data), int'(e.d));
        if (vs_counting) begin
          if (cam_vsync) vs_cnt++;
          else begin
            vs_fall     = vs_cnt;
            vs_counting = 1'b0;
          end
        end
        if (cam_href) begin
          if (!hr_sp) begin
            runs.push_back(lowrun);
            lowrun   = 0;
            href_len = 0;
            href_pulses++;
          end
          cap[(href_pulses - 1) % 2][href_len % 64] = cam_data;
          href_len++;
        end else begin
          if (hr_sp) lens.push_back(href_len);
          lowrun++;
        end
        hr_sp = cam_href;
      end
      exp_fd = fell && in_frame && (exp_q.size() == 0);
      chk("frame_done", int'(frame_done), int'(exp_fd));
      if (exp_fd) begin
        n_done++;
        if (cont_p) begin
          push_frame(int'(pat_p), int'(bar_p));
          vs_cnt      = 0;
          vs_counting = 1'b1;
        end else begin
          in_frame = 1'b0;
        end
      end
      if (fell && armed) begin
        armed    = 1'b0;
        in_frame = 1'b1;
        push_frame(int'(pat_p), int'(bar_p));
        vs_cnt      = 0;
        vs_counting = 1'b1;
      end
      if (!fell && rst_p)
        chk("hold", int'({cam_vsync, cam_href, cam_data}), int'({vs_p, hr_p, d_p}));
      chk("busy", int'(busy), int'(in_frame));
      if (start && !in_frame) armed = 1'b1;
      // CLK_DIV=3 instance: period, hold between falling edges, flat bytes
      if (!fell3 && rst_p)
        chk("hold3", int'({vsync3, href3, data3}), int'({vs3_p, hr3_p, d3_p}));
      if (rose3) begin
        if (last_rise3 >= 0) chk("pclk3_period", cyc - last_rise3, 6);
        last_rise3 = cyc;
        if (href3) begin
          chk("data3", int'(data3), (idx3 % 2 == 1) ? 128 : 200);
          idx3++;
          len3++;
        end else if (hr3_sp) begin
          lens3.push_back(len3);
          len3 = 0;
        end
        hr3_sp = href3;
      end
    end
    pclk_p = cam_pclk;
    p3_p   = pclk3;
    pat_p  = pattern;
    bar_p  = bar_col;
    cont_p = continuous;
    rst_p  = nreset;
    vs_p   = cam_vsync;
    hr_p   = cam_href;
    d_p    = cam_data;
    vs3_p  = vsync3;
    hr3_p  = href3;
    d3_p   = data3;
  end

  task automatic pulse_start();
    @(posedge sys_clk); #2 start = 1'b1;
    @(posedge sys_clk); #2 start = 1'b0;
  endtask

  task automatic clear_stats();
    href_pulses = 0;
    lowrun      = 0;
    vs_fall     = -1;
    lens.delete();
    runs.delete();
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int n = 0;
    while (n_done < target && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    chk(name, (n_done >= target) ? 1 : 0, 1);
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic wait_href(input int budget);
    int n = 0;
    while (cam_href !== 1'b1 && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    chk("href_seen", int'(cam_href), 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pclk"}, int'(cam_pclk), 0);
    chk({tag, "_vsync"}, int'(cam_vsync), 1);
    chk({tag, "_href"}, int'(cam_href), 0);
    chk({tag, "_data"}, int'(cam_data), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base, fbase;
    #12;
    chk_reset_outputs("reset");
    @(posedge sys_clk); #2 nreset = 1'b1;
    repeat (5) @(posedge sys_clk);

    // Single frame, alternating pattern
    clear_stats();
    base = n_done; fbase = fd_cnt;
    pattern = 2'd0;
    pulse_start();
    wait_frames(base + 1, 2000, "frame1_timeout");
    chk("f1_href_pulses", href_pulses, 2);
    chk("f1_len0", (lens.size() > 0) ? lens[0] : -1, 64);
    chk("f1_len1", (lens.size() > 1) ? lens[1] : -1, 64);
    chk("f1_byte0", int'(cap[0][0]), 50);
    chk("f1_byte1", int'(cap[0][1]), 128);
    chk("f1_byte2", int'(cap[0][2]), 200);
    chk("f1_last_byte", int'(cap[1][63]), 128);
    chk("f1_vsync_fall", vs_fall, 4);
    chk("f1_done_pulses", fd_cnt - fbase, 1);
    chk("f1_busy_after", int'(busy), 0);

    // Bar pattern, mid and at the right edge
    clear_stats();
    base = n_done;
    pattern = 2'd1; bar_col = 8'd10;
    pulse_start();
    wait_frames(base + 1, 2000, "bar10_timeout");
    chk("bar10_px9", int'(cap[0][18]), 200);
    chk("bar10_px10", int'(cap[0][20]), 50);
    chk("bar10_px13", int'(cap[1][26]), 50);
    chk("bar10_px14", int'(cap[0][28]), 200);
    clear_stats();
    base = n_done;
    bar_col = 8'd30;
    pulse_start();
    wait_frames(base + 1, 2000, "bar30_timeout");
    chk("bar30_px29", int'(cap[0][58]), 200);
    chk("bar30_px30", int'(cap[0][60]), 50);
    chk("bar30_px31", int'(cap[1][62]), 50);

    // Ramp, continuous for three frames, continuous dropped during the third
    clear_stats();
    base = n_done; fbase = fd_cnt;
    pattern = 2'd2; continuous = 1'b1;
    pulse_start();
    wait_frames(base + 2, 3000, "cont2_timeout");
    repeat (40) @(posedge sys_clk);
    #2 continuous = 1'b0;
    wait_frames(base + 3, 2000, "cont3_timeout");
    chk("cont_done_pulses", fd_cnt - fbase, 3);
    chk("cont_busy_after", int'(busy), 0);
    chk("ramp_l0_x0", int'(cap[0][0]), 0);
    chk("ramp_l0_x31", int'(cap[0][62]), 31);
    chk("ramp_l1_x0", int'(cap[1][0]), 1);
    chk("ramp_l1_x31", int'(cap[1][62]), 32);
    chk("cont_runs", runs.size(), 6);
    if (runs.size() == 6) begin
      chk("gap_hblank_a", runs[1], 8);
      chk("gap_frame_a", runs[2], 20);
      chk("gap_hblank_b", runs[3], 8);
      chk("gap_frame_b", runs[4], 20);
      chk("gap_hblank_c", runs[5], 8);
    end

    // Start and input changes during LINE are ignored
    clear_stats();
    base = n_done; fbase = fd_cnt;
    pattern = 2'd3;
    pulse_start();
    wait_href(500);
    @(posedge sys_clk); #2 pattern = 2'd0; bar_col = 8'd5;
    pulse_start();
    wait_frames(base + 1, 2000, "busy_start_timeout");
    chk("busy_start_done_pulses", fd_cnt - fbase, 1);
    chk("busy_start_href_pulses", href_pulses, 2);
    chk("busy_start_px0", int'(cap[0][0]), 200);
    chk("busy_start_px1", int'(cap[1][2]), 200);
    repeat (20) @(negedge sys_clk);
    chk("busy_start_idle", int'(busy), 0);

    // Asynchronous reset in the middle of a line, then a clean frame
    fbase = fd_cnt;
    pattern = 2'd1; bar_col = 8'd0;
    pulse_start();
    wait_href(500);
    repeat (10) @(negedge sys_clk);
    @(posedge sys_clk); #2 nreset = 1'b0;
    #1 chk_reset_outputs("midline_reset");
    repeat (3) @(posedge sys_clk);
    #2 nreset = 1'b1;
    repeat (10) @(negedge sys_clk);
    chk("reset_no_done", fd_cnt - fbase, 0);
    chk("reset_stays_idle", int'(busy), 0);
    clear_stats();
    base = n_done;
    pulse_start();
    wait_frames(base + 1, 2000, "after_reset_timeout");
    chk("after_reset_done", fd_cnt - fbase, 1);
    chk("after_reset_href_pulses", href_pulses, 2);
    chk("after_reset_px0", int'(cap[0][0]), 50);
    chk("after_reset_px4", int'(cap[0][8]), 200);

    // Divided pixel clock instance, flat pattern
    pattern = 2'd3;
    @(posedge sys_clk); #2 start3 = 1'b1;
    @(posedge sys_clk); #2 start3 = 1'b0;
    begin
      int n = 0;
      while (n_done3 < 1 && n < 5000) begin
        @(negedge sys_clk);
        n++;
      end
    end
    chk("div3_frame_done", n_done3, 1);
    repeat (20) @(negedge sys_clk);
    chk("div3_bytes", idx3, 128);
    chk("div3_lines", lens3.size(), 2);
    chk("div3_busy_after", int'(busy3), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cam_sensor_emulator.md
CAM_SENSOR_EMULATOR -- requirements
Module: cam_sensor_emulator

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 1, giving the cam_pclk half-period in sys_clk cycles (minimum 1).
REQ-002 The module SHALL have parameter H_PIXELS, default 32, giving pixels per line (2 bytes per pixel).
REQ-003 The module SHALL have parameter V_LINES, default 2, giving lines per frame.
REQ-004 The module SHALL have parameters VSYNC_PCLKS, VBP_PCLKS, HBLANK_PCLKS and VFP_PCLKS, defaults 4, 8, 8 and 8, giving phase lengths in pclk periods (each at least 1).
REQ-005 The module SHALL have parameters Y_DARK, Y_LIGHT and BAR_W, defaults 8'd50, 8'd200 and 4.
REQ-006 The module SHALL have these ports, clock and reset first:
  sys_clk  in  1  sole clock
  nreset  in  1  asynchronous active-low reset
  start  in  1  one-cycle pulse requesting a frame
  continuous  in  1  when 1, frames repeat back-to-back
  pattern  in  2  0 alternating, 1 bar, 2 ramp, 3 flat
  bar_col  in  8  first pixel index of the bar (pattern 1)
  cam_pclk  out  1  emulated pixel clock
  cam_vsync  out  1  frame sync, high between frames
  cam_href  out  1  line valid
  cam_data  out  8  YUV422 byte, Y first
  busy  out  1  frame in progress
  frame_done  out  1  one-cycle pulse at end of frame

Function
REQ-007 cam_pclk SHALL toggle every CLK_DIV sys_clk cycles whenever nreset=1, including while the state is IDLE.
REQ-008 A "tick" is the sys_clk cycle in which cam_pclk goes from 1 to 0; cam_vsync, cam_href and cam_data SHALL change only on ticks, so they are stable at each cam_pclk rising edge.
REQ-009 The state machine SHALL have the states IDLE, VSYNC, VBP, LINE, HBLANK and VFP.
REQ-010 IDLE SHALL hold vsync=1, href=0 and data=0; on start=1 it SHALL latch pattern and bar_col, set busy=1 and enter VSYNC.
REQ-011 VSYNC SHALL hold vsync=1 for VSYNC_PCLKS ticks, then drive vsync=0 and enter VBP.
REQ-012 VBP SHALL hold vsync=0 and href=0 for VBP_PCLKS ticks, then enter LINE.
REQ-013 LINE SHALL hold href=1 for exactly 2*H_PIXELS ticks.
REQ-014 In LINE, even bytes SHALL carry Y and odd bytes SHALL carry 8'h80.
REQ-015 On the last byte of a line that is not the last line, LINE SHALL enter HBLANK; on the last byte of the last line it SHALL enter VFP.
REQ-016 HBLANK SHALL hold href=0 and data=0 for HBLANK_PCLKS ticks, then enter LINE with the line counter incremented.
REQ-017 VFP SHALL hold href=0 for VFP_PCLKS ticks.
REQ-018 At the end of VFP, the module SHALL drive vsync=1, pulse frame_done for one sys_clk cycle, and then:
  - if continuous=1 sampled at that point, re-latch pattern and bar_col and enter VSYNC with busy held at 1;
  - otherwise enter IDLE with busy=0.
REQ-019 The Y value for pixel x (0..H_PIXELS-1) and line y SHALL be:
  - pattern 0: Y_DARK when x is even, Y_LIGHT when x is odd;
  - pattern 1: Y_DARK when bar_col <= x < bar_col+BAR_W (9-bit compare, no wrap), otherwise Y_LIGHT;
  - pattern 2: x[7:0]+y[7:0] modulo 256;
  - pattern 3: Y_LIGHT.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 start arriving between ticks SHALL be registered and acted on at the next tick.
REQ-022 Changes to pattern and bar_col during a frame SHALL have no effect until the next latch.
REQ-023 Deasserting continuous mid-frame SHALL let the current frame complete normally.
REQ-024 The pixel counter SHALL be sized for 2*H_PIXELS; the line counter SHALL be sized for V_LINES; neither SHALL wrap within a frame.

Reset
REQ-025 While nreset=0 the outputs SHALL be: cam_pclk=0, cam_vsync=1, cam_href=0, cam_data=0, busy=0, frame_done=0; the state SHALL be IDLE, and all counters and the registered start SHALL be cleared.
REQ-026 Reset asserted mid-frame SHALL force these values immediately and asynchronously, with no frame_done pulse.
REQ-027 After reset release, the module SHALL wait for a new start.

Verification
REQ-028 Single frame with defaults and pattern 0 -> the bench SHALL see:
  - exactly 2 href pulses of 64 cam_pclk rising edges each;
  - bytes sampled at rising edges of 50,128,200,128,...;
  - vsync falls 4 pclk periods after start;
  - exactly one frame_done pulse;
  - busy=0 afterwards.
REQ-029 Pattern 1 with bar_col=10 -> the Y bytes of pixels 10-13 SHALL be 50 and all other Y bytes 200; bar_col=30 -> only pixels 30-31 SHALL be 50.
REQ-030 Pattern 2 -> line 0 Y SHALL be 0..31 and line 1 Y SHALL be 1..32; continuous=1 -> 3 frames with 3 frame_done pulses, each frame gap containing exactly VFP+VSYNC+VBP = 20 pclk periods with href=0.
REQ-031 A start pulse during LINE -> no effect: frame length and a single frame_done SHALL be unchanged.
REQ-032 nreset pulsed low mid-LINE -> outputs SHALL go to their reset values within the same cycle; after release a new start SHALL produce a full, correct frame.
REQ-033 CLK_DIV=3 -> the cam_pclk period SHALL be 6 sys_clk cycles, with data changing only on cam_pclk falling edges.
